seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: six-digit multiplexed 7-segment scanner.
// A prescaler steps through the digits one slot at a time. Each slot starts with
// a short all-off guard interval so the previous digit does not ghost. New
// values are double-buffered: a load goes to a shadow register and is copied to
// the active register only at a frame boundary. A frame never mixes old and new
// digits.
module seg_scan #(
  parameter int DIV_CNT  = 50000,
  parameter int GUARD    = 16,
  parameter int BLANK_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] bcd_in,
  output logic [3:0]  digit_num,
  output logic [5:0]  digit_sel,
  output logic        upd_done
);

  localparam int            CW      = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_CNT - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [23:0]   r_shadow;
  logic [23:0]   r_active;
  logic          r_pending;
  logic          r_upd_done;
  logic [5:0]    r_digit_sel;
  logic [3:0]    r_digit_num;

  logic          w_tick;
  logic          w_frame_end;
  logic [3:0]    w_nib [6];
  logic [5:0]    w_lead_nz;
  logic [3:0]    w_cur_nib;
  logic          w_cur_nz;
  logic [5:0]    w_sel_next;
  logic [3:0]    w_num_next;

  assign w_tick      = (r_cnt == CNT_MAX);
  assign w_frame_end = w_tick && (r_idx == 3'd5);

  // w_lead_nz[i] is set when any active nibble from digit 5 down to digit i is
  // non-zero. Codes A..F count as non-zero, so they are never blanked here.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_nib
      assign w_nib[gi] = r_active[gi*4 +: 4];
      if (gi == 5) begin : g_top
        assign w_lead_nz[gi] = |w_nib[gi];
      end else begin : g_rest
        assign w_lead_nz[gi] = (|w_nib[gi]) | w_lead_nz[gi+1];
      end
    end
  endgenerate

  // Prescaler and digit index: slot advances on tick, index wraps 5 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else begin
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Shadow/active double buffer. A load on the boundary cycle bypasses the
  // shadow so it is not left pending for a whole extra frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_active   <= '0;
      r_pending  <= 1'b0;
      r_upd_done <= 1'b0;
    end else begin
      r_upd_done <= 1'b0;
      if (load) begin
        r_shadow <= bcd_in;
      end
      if (w_frame_end && load) begin
        r_active   <= bcd_in;
        r_pending  <= 1'b0;
        r_upd_done <= 1'b1;
      end else if (w_frame_end && r_pending) begin
        r_active   <= r_shadow;
        r_pending  <= 1'b0;
        r_upd_done <= 1'b1;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Next digit enable and nibble for the current slot, including blanking.
  always_comb begin
    w_cur_nib = 4'h0;
    w_cur_nz  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (r_idx == 3'(i)) begin
        w_cur_nib = w_nib[i];
        w_cur_nz  = (i == 0) ? 1'b1 : w_lead_nz[i];
      end
    end
    w_num_next = ((BLANK_EN != 0) && !w_cur_nz) ? 4'hF : w_cur_nib;
    w_sel_next = (r_cnt < GUARD_C) ? 6'h3F : ~(6'b000001 << r_idx);
  end

  // Registered outputs, one clock behind the counter and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit_sel <= 6'h3F;
      r_digit_num <= 4'hF;
    end else begin
      r_digit_sel <= w_sel_next;
      r_digit_num <= w_num_next;
    end
  end

  assign digit_sel = r_digit_sel;
  assign digit_num = r_digit_num;
  assign upd_done  = r_upd_done;

endmodule
